// File: rtl/noc_pkg.sv
// Shared NoC constants, packet field positions and receiver FSM states.
// Used by the spike receiver and the neuron-side packet transmitter.
package noc_pkg;

  localparam int FLIT_SIZE        = 4;
  localparam int PACKET_SIZE      = 32;
  localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;

  localparam int DST_X_MSB = 31;
  localparam int DST_X_LSB = 28;
  localparam int DST_Y_MSB = 27;
  localparam int DST_Y_LSB = 24;
  localparam int AXON_MSB  = 11;
  localparam int AXON_LSB  = 0;

  typedef enum logic {
    RECV   = 1'b0,
    DECODE = 1'b1
  } rx_state_t;

endpackage

// File: rtl/flit_deser.sv
// Flit deserializer: shifts flits MS-first into a packet register.
// Ports: clk, rst_n, flit_in/flit_valid/flit_ready, pkt_valid (1 cycle), pkt.
module flit_deser #(
  parameter int FLIT_SIZE   = noc_pkg::FLIT_SIZE,
  parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FLIT_SIZE-1:0]   flit_in,
  input  logic                   flit_valid,
  output logic                   flit_ready,
  output logic                   pkt_valid,
  output logic [PACKET_SIZE-1:0] pkt
);
  import noc_pkg::*;

  localparam int FPP   = PACKET_SIZE / FLIT_SIZE;
  localparam int CNT_W = (FPP > 1) ? $clog2(FPP) : 1;

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0] shreg_q;
  logic                   take;
  logic                   last;

  assign last = (cnt_q == CNT_W'(FPP - 1));
  assign pkt  = shreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flit_ready = 1'b0;
    pkt_valid  = 1'b0;
    take       = 1'b0;
    unique case (state_q)
      RECV: begin
        flit_ready = 1'b1;
        if (flit_valid) begin
          take = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = DECODE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DECODE: begin
        pkt_valid = 1'b1;
        state_d   = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (take) begin
      shreg_q <= {shreg_q[PACKET_SIZE-FLIT_SIZE-1:0], flit_in};
    end
  end

endmodule

// File: rtl/spike_packet_rx.sv
// Spike packet receiver: reassembles flits, checks X/Y/axon, drives inSpike.
// Ports: clk, rst_n, flit_in/valid/ready, start, inSpike, drop_cnt (SPIKE_RX_DROP_CNT_EN).
module spike_packet_rx #(
  parameter int FLIT_SIZE          = noc_pkg::FLIT_SIZE,
  parameter int PACKET_SIZE        = noc_pkg::PACKET_SIZE,
  parameter int NUM_AXONS          = 2,
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter int X_ID               = 1,
  parameter int Y_ID               = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 flit_valid,
  output logic                 flit_ready,
  input  logic                 start,
`ifdef SPIKE_RX_DROP_CNT_EN
  output logic [7:0]           drop_cnt,
`endif
  output logic [NUM_AXONS-1:0] inSpike
);
  import noc_pkg::*;

  logic                   pkt_valid;
  logic [PACKET_SIZE-1:0] pkt;
  logic [3:0]             dst_x;
  logic [3:0]             dst_y;
  logic [11:0]            axon;
  logic                   accept;
  logic [NUM_AXONS-1:0]   spike_set;
  logic [NUM_AXONS-1:0]   pending_q;
  logic                   unused_rsv;

  flit_deser #(
    .FLIT_SIZE  (FLIT_SIZE),
    .PACKET_SIZE(PACKET_SIZE)
  ) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit_in   (flit_in),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .pkt_valid (pkt_valid),
    .pkt       (pkt)
  );

  assign dst_x      = pkt[DST_X_MSB:DST_X_LSB];
  assign dst_y      = pkt[DST_Y_MSB:DST_Y_LSB];
  assign axon       = pkt[AXON_MSB:AXON_LSB];
  assign unused_rsv = ^pkt[DST_Y_LSB-1:AXON_MSB+1];

  assign accept = (dst_x == 4'(X_ID)) &&
                  (dst_y == 4'(Y_ID)) &&
                  (32'(axon) < 32'(NUM_AXONS));

  always_comb begin
    spike_set = '0;
    if (pkt_valid && accept) begin
      spike_set[axon[AXON_CNT_BIT_WIDTH-1:0]] = 1'b1;
    end
  end

  // A start coinciding with decode hands out the old pending
  // and seeds the cleared vector with the new spike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      inSpike   <= '0;
    end else if (start) begin
      inSpike   <= pending_q;
      pending_q <= spike_set;
    end else begin
      pending_q <= pending_q | spike_set;
    end
  end

`ifdef SPIKE_RX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (pkt_valid && !accept && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/spike_packet_rx.md
# spike_packet_rx

Local-port receiver for spike packets. Sits between the router's local output and a neuron tile's `inSpike` input. It accepts 4-bit flits, reassembles 32-bit spike packets, and checks the destination coordinates. Each valid axon index is latched into a pending spike vector, which is handed to the neuron as `inSpike` on each `start` pulse (one time step).

## Interface
Parameters:
- `FLIT_SIZE`, 4: flit width in bits.
- `PACKET_SIZE`, 32: packet width in bits; must be a multiple of `FLIT_SIZE`.
- `NUM_AXONS`, 2: number of axon inputs of the attached neuron tile.
- `AXON_CNT_BIT_WIDTH`, 1: width of axon index compared against `NUM_AXONS`.
- `X_ID`, 1: 4-bit tile X coordinate.
- `Y_ID`, 1: 4-bit tile Y coordinate.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `flit_in` in `FLIT_SIZE`: incoming flit, MS nibble first.
- `flit_valid` in 1: `flit_in` valid.
- `flit_ready` out 1: receiver can accept a flit.
- `start` in 1: one-cycle time-step pulse.
- `inSpike` out `NUM_AXONS`: spike vector for the current time step.
- `drop_cnt` out 8: dropped-packet count. Present only with the macro in Configuration.

## Operation
- Packet fields:
  - [31:28] destination X.
  - [27:24] destination Y.
  - [23:12] reserved, ignored.
  - [11:0] axon index.
- A flit transfers on a cycle with `flit_valid && flit_ready`. Flits shift into the packet register MS-first.
- FSM states:
  - RECV: `flit_ready`=1; a flit counter runs 0..`PACKET_SIZE/FLIT_SIZE`-1. Accepting the last flit moves to DECODE and wraps the counter to 0.
  - DECODE: one cycle, `flit_ready`=0. Tests the assembled packet, then returns to RECV.
- Decode rules:
  - Spike accepted if destination X == `X_ID`, destination Y == `Y_ID`, and axon index < `NUM_AXONS`. It sets `pending[axon]` (OR; duplicates within a step merge).
  - Any failed check drops the packet silently; `pending` is unchanged.
- On `start`:
  - `inSpike` <= `pending`, then `pending` <= 0. This is a single register update.
  - `inSpike` holds until the next `start`.
- `start` in the same cycle as DECODE: `inSpike` takes the pre-decode `pending`. The decoded spike lands in the freshly cleared `pending`, i.e. the next time step. No spike is ever lost or duplicated.
- `start` while in RECV mid-packet: the packet continues and its spike belongs to the next step.
- `flit_valid` low mid-packet: the counter holds; no timeout.

## Timing
- Reset values:
  - `flit_ready`=1 (FSM in RECV).
  - counter=0, `pending`=0, `inSpike`=0, `drop_cnt`=0.
- Reset mid-packet discards the partial packet immediately (asynchronous).
- Latency:
  - Last flit accepted at edge N; `pending` updated at edge N+1.
  - Visible on `inSpike` the edge after the next `start` sampled high.
- Throughput: one packet per `PACKET_SIZE/FLIT_SIZE`+1 cycles (8+1 at defaults).
- `inSpike` is registered; it changes only on the `start` edge or reset.

## Configuration
- `SPIKE_RX_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port: 8-bit saturating at 255.
  - Increments in DECODE for each dropped packet.
  - Not cleared by `start`; cleared only by reset.
- Undefined: no port, no counter; dropping behaviour is identical.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_SIZE`, `PACKET_SIZE`, `FLITS_PER_PACKET`.
  - Field bit positions (`DST_X_MSB/LSB`, `DST_Y_MSB/LSB`, `AXON_MSB/LSB`).
  - FSM state typedef.
  - These are shared with the neuron-side packet transmitter.
- One sub-module, `flit_deser`: shift register, flit counter and `flit_ready` generation. It outputs a one-cycle `pkt_valid` with the 32-bit packet.
- Address check, `pending`/`inSpike` registers and the drop counter stay in the top.

## Test plan
- Reset, then send packet 0x1100_0001 (X=1,Y=1, axon 1) as 8 flits, then pulse `start` -> `inSpike`=2'b10 after the start edge; `pending` cleared; a second `start` with no packets gives `inSpike`=2'b00.
- Packets for axon 0 and axon 1 within one step, plus a duplicate axon 0 -> `inSpike`=2'b11 after `start`.
- Packet 0x2100_0000 (X mismatch) and 0x1100_0005 (axon out of range) -> `inSpike`=2'b00; `drop_cnt`=2 with `SPIKE_RX_DROP_CNT_EN`.
- `start` asserted exactly in the DECODE cycle of an axon-0 packet -> `inSpike`=2'b00 for that step, 2'b01 after the following `start`.
- Stall with `flit_valid` low for 5 cycles after flit 3, and assert `rst_n` low mid-packet in a second run -> stalled packet decodes correctly. After reset, `flit_ready`=1, counter 0, and the next full packet decodes correctly.
- 300 dropped packets with the macro on -> `drop_cnt` saturates at 255.
